// File: rtl/x_therm_pkg.sv
// rtl/x_therm_pkg.sv - shared types and helpers for the thermometer encoder
package x_therm_pkg;

   // Element mapping selected per sample; the reserved encoding maps like plain.
   typedef enum logic [1:0] {
      THERM_PLAIN = 2'd0,
      THERM_EDGE  = 2'd1,
      THERM_DWA   = 2'd2,
      THERM_RSVD  = 2'd3
   } therm_mode_e;

   // Smallest legal element count.
   localparam int THERM_N_MIN = 4;

   // Width of a rotation pointer that addresses n unit elements.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/x_rotl.sv
// rtl/x_rotl.sv - combinational N-bit barrel rotate-left
module x_rotl #(
   parameter int N  = 64,
   parameter int AW = $clog2(N)
) (
   input  logic [N-1:0]  i_data,
   input  logic [AW-1:0] i_amt,
   output logic [N-1:0]  o_data
);

   // Stage s rotates by 2**s when amount bit s is set; log2(N) stages in series.
   for (genvar s = 0; s < AW; s++) begin : g_stage
      localparam int SH = 1 << s;
      logic [N-1:0] src;
      logic [N-1:0] dst;

      if (s == 0) begin : g_first
         assign src = i_data;
      end else begin : g_chain
         assign src = g_stage[s-1].dst;
      end

      assign dst = i_amt[s] ? {src[N-1-SH:0], src[N-1:N-SH]} : src;
   end

   assign o_data = g_stage[AW-1].dst;

endmodule

// File: rtl/x_dwa_therm.sv
// rtl/x_dwa_therm.sv - two-stage binary-to-thermometer encoder with plain/edge/DWA mapping
module x_dwa_therm
   import x_therm_pkg::*;
#(
   parameter  int N  = 64,
   localparam int W  = $clog2(N) + 1,
   localparam int PW = ptr_width(N)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   input  logic [W-1:0]  i_bin,
   input  logic [1:0]    i_mode,
   input  logic          i_ptr_clr,
   output logic          o_valid,
   output logic [N-1:0]  o_therm,
   output logic [PW-1:0] o_ptr
);

   localparam logic [W-1:0]  CODE_MAX = W'(N);
   localparam logic [PW:0]   N_WIDE   = (PW+1)'(N);
   localparam logic [N:0]    ONE_WIDE = (N+1)'(1);

   therm_mode_e   mode_in;
   logic [W-1:0]  code_sat;
   logic          mode_chg;
   logic [PW-1:0] ptr_use;
   logic [PW:0]   ptr_sum;
   logic [PW-1:0] ptr_adv;

   logic [PW-1:0] ptr_q, ptr_d;
   therm_mode_e   mode_q;
   logic          s1_valid_q;
   logic [W-1:0]  s1_code_q;
   logic [PW-1:0] s1_ptr_q;

   logic [N-1:0]  t_base;
   logic [N-1:0]  t_edge;
   logic [N-1:0]  t_rot;
   logic [N-1:0]  t_mapped;

   logic [N-1:0]  therm_q;
   logic          valid_q;

   assign mode_in  = therm_mode_e'(i_mode);
   assign code_sat = (i_bin > CODE_MAX) ? CODE_MAX : i_bin;

   // A sample in a different mode from the previous sample starts DWA from element 0.
   assign mode_chg = (mode_in != mode_q);
   assign ptr_use  = (i_ptr_clr || mode_chg) ? '0 : ptr_q;

   // Sum fits in PW+1 bits because code <= N, so one conditional subtract wraps it.
   assign ptr_sum  = {1'b0, ptr_use} + code_sat;
   assign ptr_adv  = PW'(ptr_sum - ((ptr_sum >= N_WIDE) ? N_WIDE : '0));

   // Pointer next state: advance on DWA samples, otherwise keep (possibly cleared) value.
   always_comb begin
      ptr_d = ptr_q;
      if (i_valid) begin
         ptr_d = (mode_in == THERM_DWA) ? ptr_adv : ptr_use;
      end else if (i_ptr_clr) begin
         ptr_d = '0;
      end
   end

   // Stage 1: capture saturated code, mode and encoding pointer; update the pointer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q      <= '0;
         mode_q     <= THERM_PLAIN;
         s1_valid_q <= 1'b0;
         s1_code_q  <= '0;
         s1_ptr_q   <= '0;
      end else begin
         ptr_q      <= ptr_d;
         s1_valid_q <= i_valid;
         if (i_valid) begin
            mode_q    <= mode_in;
            s1_code_q <= code_sat;
            s1_ptr_q  <= ptr_use;
         end
      end
   end

   // Base thermometer: low 'code' bits set; code = N wraps to all ones after truncation.
   assign t_base = N'((ONE_WIDE << s1_code_q) - ONE_WIDE);

   // Edge-creep: even base bits fill from bit 0 upward, odd bits from bit N-1 downward.
   for (genvar i = 0; i < N; i++) begin : g_edge
      if ((i % 2) == 0) begin : g_even
         assign t_edge[i/2] = t_base[i];
      end else begin : g_odd
         assign t_edge[N-1-(i/2)] = t_base[i];
      end
   end

   x_rotl #(
      .N  (N),
      .AW (PW)
   ) u_rotl (
      .i_data (t_base),
      .i_amt  (s1_ptr_q),
      .o_data (t_rot)
   );

   // Select the element mapping for the sample held in stage 1.
   always_comb begin
      t_mapped = t_base;
      case (mode_q)
         THERM_EDGE: t_mapped = t_edge;
         THERM_DWA:  t_mapped = t_rot;
         default:    t_mapped = t_base;
      endcase
   end

   // Stage 2: register the mapped pattern; hold it between samples.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         therm_q <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            therm_q <= t_mapped;
         end
      end
   end

   assign o_valid = valid_q;
   assign o_therm = therm_q;
   assign o_ptr   = ptr_q;

endmodule
